s2p_param: RTL and testbench

S2P_PARAM -- requirements
Module: s2p_param

---
 rtl/s2p_pkg.sv | 13 +
 rtl/s2p_bitcnt.sv | 41 ++++
 rtl/s2p_param.sv | 92 +++++++++
 tb/tb_s2p_param.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/s2p_pkg.sv
// s2p shared package: width limits and the bit-counter width helper.
// Imported by s2p_param and s2p_bitcnt.
package s2p_pkg;

  localparam int S2P_DEFAULT_WIDTH = 8;
  localparam int S2P_MAX_WIDTH     = 32;

  // bitcnt must hold 0..WIDTH-1 and match the top-level port width
  function automatic int s2p_cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/s2p_bitcnt.sv
// s2p_bitcnt: counts bits of the partial word, wraps on the WIDTH-th bit.
// Ports: clk, nreset (sync, active-low), clr, en -> cnt, wrap (completion).
module s2p_bitcnt
  import s2p_pkg::*;
#(
  parameter int WIDTH = S2P_DEFAULT_WIDTH
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic                          clr,
  input  logic                          en,
  output logic [s2p_cnt_w(WIDTH)-1:0]   cnt,
  output logic                          wrap
);

  localparam int CW = s2p_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // wrap marks the edge that captures the last bit of a word
  assign wrap = en && !clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!nreset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/s2p_param.sv
// s2p_param: serial-to-parallel converter with holding register,
// valid/ready output handshake and sticky overrun flag.
// Ports: clk, nreset, en, sin, clr, pready -> pout, pvalid, bitcnt, overrun.
module s2p_param
  import s2p_pkg::*;
#(
  parameter int WIDTH     = S2P_DEFAULT_WIDTH,
  parameter int LSB_FIRST = 0
) (
  input  logic                        clk,
  input  logic                        nreset,
  input  logic                        en,
  input  logic                        sin,
  input  logic                        clr,
  output logic [WIDTH-1:0]            pout,
  output logic                        pvalid,
  input  logic                        pready,
  output logic [s2p_cnt_w(WIDTH)-1:0] bitcnt,
  output logic                        overrun
);

  if (WIDTH < 2 || WIDTH > S2P_MAX_WIDTH) begin : g_width_chk
    $error("s2p_param: WIDTH must be in 2..32");
  end

  logic [WIDTH-1:0] sh_q, sh_d, sh_nxt;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             pvalid_q, pvalid_d;
  logic             ovr_q, ovr_d;
  logic             wrap;
  logic             free;

  s2p_bitcnt #(
    .WIDTH (WIDTH)
  ) u_bitcnt (
    .clk    (clk),
    .nreset (nreset),
    .clr    (clr),
    .en     (en),
    .cnt    (bitcnt),
    .wrap   (wrap)
  );

  // LSB_FIRST=0: first bit ends in MSB; =1: first bit ends in LSB
  assign sh_nxt = (LSB_FIRST != 0) ? {sin, sh_q[WIDTH-1:1]}
                                   : {sh_q[WIDTH-2:0], sin};

  // a pending word being accepted this edge frees the holding register
  assign free = !pvalid_q || pready;

  always_comb begin
    sh_d     = sh_q;
    pout_d   = pout_q;
    pvalid_d = pvalid_q;
    ovr_d    = ovr_q;
    if (pvalid_q && pready)
      pvalid_d = 1'b0;
    if (clr) begin
      sh_d  = '0;
      ovr_d = 1'b0;
    end else if (en) begin
      sh_d = sh_nxt;
      if (wrap) begin
        if (free) begin
          pout_d   = sh_nxt;
          pvalid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      sh_q     <= '0;
      pout_q   <= '0;
      pvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sh_q     <= sh_d;
      pout_q   <= pout_d;
      pvalid_q <= pvalid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign pout    = pout_q;
  assign pvalid  = pvalid_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_s2p_param.sv
// Bench for s2p_param: four instances (W4/W8 x LSB_FIRST 0/1) on one stream,
// checked each cycle against a bit-list model plus literal expectations.
module tb_s2p_param;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic en = 1'b0;
  logic sin = 1'b0;
  logic clr = 1'b0;
  logic pready = 1'b0;

  always #5 clk = ~clk;

  logic [3:0] p0, p1;
  logic [7:0] p2, p3;
  logic [2:0] c0, c1;
  logic [3:0] c2, c3;
  logic       v0, v1, v2, v3;
  logic       o0, o1, o2, o3;

  s2p_param #(.WIDTH(4), .LSB_FIRST(0)) u0 (
    .clk(clk), .nreset(nreset), .en(en), .sin(sin), .clr(clr),
    .pout(p0), .pvalid(v0), .pready(pready), .bitcnt(c0), .overrun(o0));
  s2p_param #(.WIDTH(4), .LSB_FIRST(1)) u1 (
    .clk(clk), .nreset(nreset), .en(en), .sin(sin), .clr(clr),
    .pout(p1), .pvalid(v1), .pready(pready), .bitcnt(c1), .overrun(o1));
  s2p_param #(.WIDTH(8), .LSB_FIRST(0)) u2 (
    .clk(clk), .nreset(nreset), .en(en), .sin(sin), .clr(clr),
    .pout(p2), .pvalid(v2), .pready(pready), .bitcnt(c2), .overrun(o2));
  s2p_param #(.WIDTH(8), .LSB_FIRST(1)) u3 (
    .clk(clk), .nreset(nreset), .en(en), .sin(sin), .clr(clr),
    .pout(p3), .pvalid(v3), .pready(pready), .bitcnt(c3), .overrun(o3));

  logic [31:0] d_pout [4];
  logic [31:0] d_cnt  [4];
  logic        d_pv   [4];
  logic        d_ov   [4];

  assign d_pout[0] = 32'(p0);
  assign d_pout[1] = 32'(p1);
  assign d_pout[2] = 32'(p2);
  assign d_pout[3] = 32'(p3);
  assign d_cnt[0]  = 32'(c0);
  assign d_cnt[1]  = 32'(c1);
  assign d_cnt[2]  = 32'(c2);
  assign d_cnt[3]  = 32'(c3);
  assign d_pv[0] = v0;
  assign d_pv[1] = v1;
  assign d_pv[2] = v2;
  assign d_pv[3] = v3;
  assign d_ov[0] = o0;
  assign d_ov[1] = o1;
  assign d_ov[2] = o2;
  assign d_ov[3] = o3;

  int unsigned mw [4] = '{4, 4, 8, 8};
  bit          ml [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  // model: list of received bits, word assembled by bit position
  int          m_n    [4];
  bit          m_seq  [4][32];
  logic [31:0] m_pout [4];
  bit          m_pv   [4];
  bit          m_ov   [4];

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t act=%0h exp=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      bit acc;
      bit fr;
      logic [31:0] w;
      acc = m_pv[i] && pready;
      fr  = !m_pv[i] || pready;
      if (!nreset) begin
        m_n[i] = 0; m_pout[i] = '0; m_pv[i] = 0; m_ov[i] = 0;
      end else begin
        if (acc) m_pv[i] = 0;
        if (clr) begin
          m_n[i] = 0; m_ov[i] = 0;
        end else if (en) begin
          m_seq[i][m_n[i]] = sin;
          m_n[i]++;
          if (m_n[i] == int'(mw[i])) begin
            m_n[i] = 0;
            w = '0;
            for (int k = 0; k < int'(mw[i]); k++) begin
              if (ml[i]) w[k] = m_seq[i][k];
              else       w[int'(mw[i]) - 1 - k] = m_seq[i][k];
            end
            if (fr) begin
              m_pout[i] = w; m_pv[i] = 1;
            end else begin
              m_ov[i] = 1;
            end
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("pout[%0d]", i), d_pout[i], m_pout[i]);
        chk($sformatf("pvalid[%0d]", i), 32'(d_pv[i]), 32'(m_pv[i]));
        chk($sformatf("bitcnt[%0d]", i), d_cnt[i], 32'(m_n[i]));
        chk($sformatf("overrun[%0d]", i), 32'(d_ov[i]), 32'(m_ov[i]));
      end
    end
  end

  task automatic step(input bit e, input bit s, input bit c, input bit r);
    en = e; sin = s; clr = c; pready = r;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic bits4(input logic [3:0] b, input bit r);
    logic [3:0] v;
    v = b;
    for (int k = 3; k >= 0; k--) step(1'b1, v[k], 1'b0, r);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_n[i] = 0; m_pout[i] = '0; m_pv[i] = 0; m_ov[i] = 0;
    end
    nreset = 1'b0;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    armed = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_pout", d_pout[0], 32'h0);
    chk("rst_pvalid", 32'(d_pv[2]), 32'h0);
    chk("rst_bitcnt", d_cnt[3], 32'h0);
    chk("rst_overrun", 32'(d_ov[1]), 32'h0);
    nreset = 1'b1;

    // V1/V2: 1,0,1,1 with pready=1
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("v1_cnt1", d_cnt[0], 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("v1_cnt2", d_cnt[0], 32'd2);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("v1_cnt3", d_cnt[0], 32'd3);
    chk("v1_pv_early", 32'(d_pv[0]), 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("v1_cnt0", d_cnt[0], 32'd0);
    chk("v1_pout", d_pout[0], 32'hB);
    chk("v1_pvalid", 32'(d_pv[0]), 32'h1);
    chk("v2_pout", d_pout[1], 32'hD);
    chk("v1_w8_cnt", d_cnt[2], 32'd4);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("v1_pv_drop", 32'(d_pv[0]), 32'h0);
    chk("v1_pout_hold", d_pout[0], 32'hB);

    // V3: pause mid-word
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      chk("v3_hold", d_cnt[0], 32'd2);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("v3_pout", d_pout[0], 32'h9);
    chk("v3_pout_lsb", d_pout[1], 32'h9);
    chk("v3_w8_pout", d_pout[2], 32'hB9);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // V4: overrun with pready=0
    bits4(4'hA, 1'b0);
    chk("v4_first", d_pout[0], 32'hA);
    bits4(4'h5, 1'b0);
    chk("v4_pout", d_pout[0], 32'hA);
    chk("v4_pvalid", 32'(d_pv[0]), 32'h1);
    chk("v4_overrun", 32'(d_ov[0]), 32'h1);
    chk("v4_w8_pout", d_pout[2], 32'hA5);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("v4_sticky", 32'(d_ov[0]), 32'h1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("v4_clr_ov", 32'(d_ov[0]), 32'h0);
    chk("v4_clr_pout", d_pout[0], 32'hA);
    chk("v4_clr_pv", 32'(d_pv[0]), 32'h1);
    chk("v4_clr_cnt", d_cnt[0], 32'd0);

    // V5: pready rises on the completion edge
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("v5_pout", d_pout[0], 32'h3);
    chk("v5_pvalid", 32'(d_pv[0]), 32'h1);
    chk("v5_overrun", 32'(d_ov[0]), 32'h0);

    // V6: reset mid-word with pvalid=1
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    nreset = 1'b0;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("v6_pout", d_pout[0], 32'h0);
    chk("v6_pvalid", 32'(d_pv[0]), 32'h0);
    chk("v6_cnt", d_cnt[0], 32'd0);
    chk("v6_w8_cnt", d_cnt[2], 32'd0);
    nreset = 1'b1;
    bits4(4'hD, 1'b1);
    chk("v6_pout4", d_pout[0], 32'hD);
    chk("v6_cnt4", d_cnt[2], 32'd4);
    bits4(4'h6, 1'b1);
    chk("v6_w8_msb", d_pout[2], 32'hD6);
    chk("v6_w8_lsb", d_pout[3], 32'h6B);

    // mixed traffic checked by the model
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 2) == 0));
    end

    step(1'b0, 1'b0, 1'b0, 1'b0);
    armed = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
